// File: rtl/proposal_sram_packer.sv
// Packs a valid/ready byte stream into Q-byte rows and issues one masked SRAM write per row.
// Optional: define PROPOSAL_PACK_ZERO_FILL_EN to write partial rows in full with zeroed unused bytes.
module proposal_sram_packer #(
    parameter int ADDR_SPACE = 4,
    parameter int Q          = 16,
    parameter int BW         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BW-1:0]         in_data,
    input  logic                  in_last,
    output logic                  sram_wsb,
    output logic [BW*Q-1:0]       sram_wdata,
    output logic [Q-1:0]          sram_bytemask,
    output logic [ADDR_SPACE-1:0] sram_waddr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_SPACE:0]   row_count
);
    localparam int                    IDXW     = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(Q - 1);
    localparam logic [ADDR_SPACE-1:0] TOP_ROW  = '1;
`ifdef PROPOSAL_PACK_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
    state_t r_state, w_state_nxt;

    logic [IDXW-1:0]       r_idx;
    logic [ADDR_SPACE-1:0] r_row;
    logic [ADDR_SPACE:0]   r_row_count;
    logic [Q-1:0][BW-1:0]  r_buf;
    logic                  r_wsb;
    logic [Q-1:0][BW-1:0]  r_wdata;
    logic [Q-1:0]          r_mask;
    logic [ADDR_SPACE-1:0] r_waddr;
    logic                  r_done;

    logic                  w_xfer;
    logic                  w_row_done;
    logic                  w_frame_end;
    logic                  w_start;
    logic [Q-1:0][BW-1:0]  w_row;
    logic [Q-1:0][BW-1:0]  w_wdata;
    logic [Q-1:0]          w_mask;

    assign w_xfer      = in_valid && (r_state == S_RUN);
    assign w_row_done  = w_xfer && (in_last || (r_idx == LAST_IDX));
    // The top row ends the frame even without in_last; the address never wraps.
    assign w_frame_end = w_row_done && (in_last || (r_row == TOP_ROW));
    assign w_start     = start && (r_state == S_IDLE);

    assign in_ready      = (r_state == S_RUN);
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign row_count     = r_row_count;
    assign sram_wsb      = r_wsb;
    assign sram_wdata    = r_wdata;
    assign sram_bytemask = r_mask;
    assign sram_waddr    = r_waddr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_frame_end) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Row image including the byte on the bus, so a completing transfer writes without a stall.
    always_comb begin
        w_row        = r_buf;
        w_row[r_idx] = in_data;
        w_wdata      = w_row;
        w_mask       = '0;
        for (int k = 0; k < Q; k++) begin
            if (r_idx < IDXW'(k)) begin
                w_wdata[k] = ZERO_FILL ? '0 : w_row[k];
                w_mask[k]  = ~ZERO_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_row       <= '0;
            r_row_count <= '0;
            r_buf       <= '0;
            r_wsb       <= 1'b1;
            r_wdata     <= '0;
            r_mask      <= '1;
            r_waddr     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wsb   <= 1'b1;
            r_mask  <= '1;
            r_done  <= (r_state == S_FLUSH);
            if (w_start) begin
                r_idx       <= '0;
                r_row       <= '0;
                r_row_count <= '0;
            end
            if (w_xfer) begin
                r_buf <= w_row;
                r_idx <= w_row_done ? '0 : r_idx + 1'b1;
            end
            if (w_row_done) begin
                r_wsb       <= 1'b0;
                r_wdata     <= w_wdata;
                r_mask      <= w_mask;
                r_waddr     <= r_row;
                r_row       <= r_row + 1'b1;
                r_row_count <= r_row_count + 1'b1;
            end
        end
    end
endmodule
